// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register: valid/ready handshake with a
// one-entry skid buffer and flush-to-bubble masking of control bits.
module pipe_stage_reg #(
  parameter int CTRL_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter logic [CTRL_WIDTH-1:0] FLUSH_MASK = '1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_BUSY  = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b10;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [CTRL_WIDTH-1:0] r_main_ctrl;
  logic [DATA_WIDTH-1:0] r_main_data;
  logic [CTRL_WIDTH-1:0] r_skid_ctrl;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [CTRL_WIDTH-1:0] w_main_ctrl_nxt;
  logic [DATA_WIDTH-1:0] w_main_data_nxt;
  logic                  w_accept;
  logic                  w_drain;
  logic                  w_load_in;
  logic                  w_load_skid;
  logic                  w_skid_wr;

  // Handshake outputs come from registered state only.
  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_in   = 1'b0;
    w_load_skid = 1'b0;
    w_skid_wr   = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_load_in   = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_accept && w_drain) begin
            w_load_in = 1'b1;
          end else if (w_accept) begin
            w_skid_wr   = 1'b1;
            w_state_nxt = S_FULL;
          end else if (w_drain) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_drain) begin
            w_load_skid = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Any move to EMPTY strips the critical control bits from the bubble.
  always_comb begin
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    if (w_load_in) begin
      w_main_ctrl_nxt = in_ctrl;
      w_main_data_nxt = in_data;
    end else if (w_load_skid) begin
      w_main_ctrl_nxt = r_skid_ctrl;
      w_main_data_nxt = r_skid_data;
    end
    if (w_state_nxt == S_EMPTY) begin
      w_main_ctrl_nxt = r_main_ctrl & ~FLUSH_MASK;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      if (flush) begin
        r_skid_ctrl <= '0;
        r_skid_data <= '0;
      end else if (w_skid_wr) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed handshake/flush/reset
// vectors followed by a random in_valid/out_ready/flush soak.
module tb_pipe_stage_reg;

  localparam logic [7:0] MASK = 8'h0F;

  typedef struct packed {
    logic [7:0]  c;
    logic [15:0] d;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_ctrl = '0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_ctrl;
  logic [15:0] out_data;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always #5 clock = ~clock;

  pipe_stage_reg #(
    .CTRL_WIDTH(8),
    .DATA_WIDTH(16),
    .FLUSH_MASK(MASK)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Record what the DUT must accept at the coming edge, then advance.
  task automatic tick();
    if (reset || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic v, logic [7:0] c, logic [15:0] d, logic r);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = r;
  endtask

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (!out_valid) begin
        n_checks++;
        if ((out_ctrl & MASK) != 8'h00) begin
          n_fail++;
          $display("FAIL bubble: out_ctrl %0h with mask %0h", out_ctrl, MASK);
        end
      end
      if (!flush && out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_spurious: got %0h/%0h expected none",
                   out_ctrl, out_data);
        end else begin
          ent_t e;
          e = sb.pop_front();
          if (out_ctrl !== e.c || out_data !== e.d) begin
            n_fail++;
            $display("FAIL sb_order: got %0h/%0h expected %0h/%0h",
                     out_ctrl, out_data, e.c, e.d);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ctrl", 32'(out_ctrl), 32'h00);
    check("rst_data", 32'(out_data), 32'h0000);
    check("rst_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(i + 1), 16'(16'h1000 + i), 1'b1);
      tick();
      check("str_valid", 32'(out_valid), 32'd1);
      check("str_ctrl", 32'(out_ctrl), 32'(i + 1));
      check("str_data", 32'(out_data), 32'(16'h1000 + i));
      check("str_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    tick();
    check("str_empty", 32'(out_valid), 32'd0);
    check("str_bub", 32'(out_ctrl), 32'h00);

    drive(1'b1, 8'h01, 16'h2001, 1'b1);
    tick();
    drive(1'b1, 8'h02, 16'h2002, 1'b0);
    tick();
    check("bp_ready", 32'(in_ready), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_ctrl", 32'(out_ctrl), 32'h01);
    check("bp_data", 32'(out_data), 32'h2001);
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    tick();
    check("bp_rec_ctrl", 32'(out_ctrl), 32'h02);
    check("bp_rec_data", 32'(out_data), 32'h2002);
    check("bp_rec_rdy", 32'(in_ready), 32'd1);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    drive(1'b1, 8'hA5, 16'h3001, 1'b1);
    tick();
    drive(1'b1, 8'h5A, 16'h3002, 1'b0);
    tick();
    check("fl_full", 32'(in_ready), 32'd0);
    drive(1'b1, 8'h77, 16'h3003, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ctrl", 32'(out_ctrl), 32'hA0);
    check("fl_data", 32'(out_data), 32'h3001);
    check("fl_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    tick();
    check("fl_gone", 32'(out_valid), 32'd0);
    drive(1'b1, 8'h11, 16'h3004, 1'b1);
    tick();
    check("fl_acc_v", 32'(out_valid), 32'd1);
    check("fl_acc_c", 32'(out_ctrl), 32'h11);

    drive(1'b1, 8'hFF, 16'h4000, 1'b1);
    tick();
    check("dr_ctrl", 32'(out_ctrl), 32'hFF);
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    tick();
    check("dr_valid", 32'(out_valid), 32'd0);
    check("dr_ctrl_b", 32'(out_ctrl), 32'hF0);
    check("dr_data", 32'(out_data), 32'h4000);

    drive(1'b1, 8'h21, 16'h5001, 1'b0);
    tick();
    drive(1'b1, 8'h22, 16'h5002, 1'b0);
    tick();
    check("rs_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_ctrl", 32'(out_ctrl), 32'h00);
    check("rs_data", 32'(out_data), 32'h0000);
    check("rs_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    tick();
    check("rs_after", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10000; i++) begin
      drive(($urandom % 4) != 0, 8'($urandom), 16'($urandom),
            ($urandom % 4) != 0);
      flush = (($urandom % 64) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("rnd_sb_empty", 32'(sb.size()), 32'd0);
    check("rnd_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
